// File: rtl/hls_deadlock_monitor_gen_if.sv
// Stall/idle inputs and deadlock report outputs of one dataflow-region monitor.
interface hls_deadlock_monitor_gen_if #(
    parameter int unsigned NUM_PROC = 2,
    parameter int unsigned NUM_AXIS = 3,
    parameter int unsigned CNT_W    = 8
);
    localparam int unsigned IDX_W = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;

    logic [NUM_AXIS-1:0]          axis_block_sigs;
    logic [NUM_PROC-1:0]          inst_idle_sigs;
    logic [NUM_PROC-1:0]          inst_block_sigs;
    logic [NUM_PROC-1:0]          sub_block_sigs;
    logic                         clear;
    logic                         block;
    logic                         block_event;
    logic [NUM_AXIS*NUM_AXIS-1:0] axis_block_info;
    logic [IDX_W-1:0]             first_axis_idx;
    logic [CNT_W-1:0]             event_count;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block_sigs, clear,
        input  block, block_event, axis_block_info, first_axis_idx, event_count
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block_sigs, clear,
        output block, block_event, axis_block_info, first_axis_idx, event_count
    );
endinterface

// File: rtl/hls_deadlock_monitor_gen.sv
// Deadlock monitor for one HLS dataflow region: qualifies an all-stopped-with-AXIS-stall
// condition over HOLD_CYCLES, reports it with a snapshot of the blocking AXIS channels.
module hls_deadlock_monitor_gen #(
    parameter int unsigned                   NUM_PROC      = 2,
    parameter int unsigned                   NUM_AXIS      = 3,
    parameter logic [NUM_PROC*NUM_AXIS-1:0]  PROC_AXIS_MAP = '1,
    parameter int unsigned                   HOLD_CYCLES   = 1,
    parameter int unsigned                   STICKY        = 1,
    parameter int unsigned                   CNT_W         = 8
) (
    input logic                        clock,
    input logic                        reset,
    hls_deadlock_monitor_gen_if.slave  mon
);
    localparam int unsigned IDX_W  = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned INFO_W = NUM_AXIS * NUM_AXIS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMING  = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    logic [1:0]          state, state_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic                block_q, block_n;
    logic                event_q, event_n;
    logic [INFO_W-1:0]   info_q, info_n, info_fresh;
    logic [IDX_W-1:0]    idx_q, idx_n, idx_fresh;
    logic [CNT_W-1:0]    count_q, count_n;
    logic [NUM_PROC-1:0] pab;
    logic                has_axis, stop, cond, entering, frozen;

    // Region-level deadlock condition: every process stopped, at least one on an AXIS stall
    always_comb begin
        stop = 1'b1;
        for (int p = 0; p < int'(NUM_PROC); p++) begin
            pab[p] = mon.sub_block_sigs[p]
                   & (|(mon.axis_block_sigs & PROC_AXIS_MAP[p*NUM_AXIS +: NUM_AXIS]));
            stop   = stop & (mon.inst_idle_sigs[p] | mon.inst_block_sigs[p] | pab[p]);
        end
        has_axis = |pab;
        cond     = has_axis & stop;
    end

    // Fresh per-axis info fields and lowest stalled axis index
    always_comb begin
        info_fresh = '0;
        idx_fresh  = '0;
        for (int a = 0; a < int'(NUM_AXIS); a++) begin
            info_fresh[a*NUM_AXIS +: NUM_AXIS] =
                mon.axis_block_sigs[a] ? ~(NUM_AXIS'(1) << a) : '0;
        end
        for (int a = int'(NUM_AXIS) - 1; a >= 0; a--) begin
            if (mon.axis_block_sigs[a]) idx_fresh = IDX_W'(a);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (mon.clear) begin
                    hold_cnt_n = '0;
                end else if (cond) begin
                    if (HOLD_CYCLES == 1) begin
                        state_n = ST_BLOCKED;
                    end else begin
                        state_n    = ST_ARMING;
                        hold_cnt_n = HOLD_W'(1);
                    end
                end
            end
            ST_ARMING: begin
                if (mon.clear) begin
                    hold_cnt_n = '0;
                end else if (!cond) begin
                    state_n    = ST_IDLE;
                    hold_cnt_n = '0;
                end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_n    = ST_BLOCKED;
                    hold_cnt_n = '0;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            ST_BLOCKED: begin
                if (mon.clear) begin
                    state_n    = ST_IDLE;
                    hold_cnt_n = '0;
                end else if (STICKY == 0 && !cond) begin
                    state_n    = ST_IDLE;
                    hold_cnt_n = '0;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                hold_cnt_n = '0;
            end
        endcase

        entering = (state_n == ST_BLOCKED) && (state != ST_BLOCKED);
        // Snapshot holds while latched; otherwise it tracks the channels every cycle
        frozen   = (state == ST_BLOCKED) && (STICKY != 0);
        block_n  = (state_n == ST_BLOCKED);
        event_n  = entering;
        info_n   = block_n ? (frozen ? info_q : info_fresh) : '0;
        idx_n    = frozen ? idx_q : idx_fresh;

        count_n = count_q;
        if (mon.clear) begin
            count_n = '0;
        end else if (entering && (count_q != {CNT_W{1'b1}})) begin
            count_n = count_q + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            block_q  <= 1'b0;
            event_q  <= 1'b0;
            info_q   <= '0;
            idx_q    <= '0;
            count_q  <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
            block_q  <= block_n;
            event_q  <= event_n;
            info_q   <= info_n;
            idx_q    <= idx_n;
            count_q  <= count_n;
        end
    end

    assign mon.block           = block_q;
    assign mon.block_event     = event_q;
    assign mon.axis_block_info = info_q;
    assign mon.first_axis_idx  = idx_q;
    assign mon.event_count     = count_q;
endmodule

// File: tb/tb_hls_deadlock_monitor_gen.sv
// Scoreboard bench: four monitor configurations share one randomized stimulus stream.
module tb_hls_deadlock_monitor_gen;
    localparam int NI = 4;

    typedef struct {
        bit rst;
        bit blk;
        bit evt;
        int info;
        int idx;
        int cnt;
    } exp_t;

    // Per-instance configuration: hold, sticky, counter max, process->axis map
    int hold_c[NI]  = '{1, 4, 1, 3};
    int sticky_c[NI] = '{1, 1, 0, 0};
    int cmax_c[NI]  = '{255, 255, 255, 3};
    int map_c[NI]   = '{6'b111111, 6'b111111, 6'b111011, 6'b111111};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hls_deadlock_monitor_gen_if #(.NUM_PROC(2), .NUM_AXIS(3), .CNT_W(8)) if0 ();
    hls_deadlock_monitor_gen_if #(.NUM_PROC(2), .NUM_AXIS(3), .CNT_W(8)) if1 ();
    hls_deadlock_monitor_gen_if #(.NUM_PROC(2), .NUM_AXIS(3), .CNT_W(8)) if2 ();
    hls_deadlock_monitor_gen_if #(.NUM_PROC(2), .NUM_AXIS(3), .CNT_W(2)) if3 ();

    hls_deadlock_monitor_gen u0 (.clock(clock), .reset(reset), .mon(if0));
    hls_deadlock_monitor_gen #(.HOLD_CYCLES(4)) u1 (.clock(clock), .reset(reset), .mon(if1));
    hls_deadlock_monitor_gen #(.PROC_AXIS_MAP(6'b111011), .STICKY(0))
        u2 (.clock(clock), .reset(reset), .mon(if2));
    hls_deadlock_monitor_gen #(.HOLD_CYCLES(3), .STICKY(0), .CNT_W(2))
        u3 (.clock(clock), .reset(reset), .mon(if3));

    exp_t exp_q[NI][$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: latched flag, run length of consecutive deadlock cycles
    bit m_blk[NI];
    int m_run[NI];
    int m_cnt[NI];
    int m_info[NI];
    int m_idx[NI];

    function automatic bit deadlocked(int i, logic [2:0] ax, logic [1:0] idl,
                                      logic [1:0] ib, logic [1:0] sb);
        bit any_axis = 0;
        bit all_stop = 1;
        for (int p = 0; p < 2; p++) begin
            bit hit = ((map_c[i] >> (3 * p)) & 7 & int'(ax)) != 0;
            bit stalled = sb[p] && hit;
            any_axis |= stalled;
            if (!(idl[p] || ib[p] || stalled)) all_stop = 0;
        end
        return any_axis && all_stop;
    endfunction

    function automatic int info_of(logic [2:0] ax);
        int r = 0;
        for (int a = 0; a < 3; a++)
            if (ax[a]) r += (7 - (1 << a)) * (1 << (3 * a));
        return r;
    endfunction

    function automatic int low_of(logic [2:0] ax);
        for (int a = 0; a < 3; a++) if (ax[a]) return a;
        return 0;
    endfunction

    function automatic void model_step(int i, bit rst, logic [2:0] ax, logic [1:0] idl,
                                       logic [1:0] ib, logic [1:0] sb, bit clr);
        bit c = deadlocked(i, ax, idl, ib, sb);
        bit evt = 0;
        exp_t e;
        if (rst) begin
            m_blk[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_info[i] = 0; m_idx[i] = 0;
        end else if (m_blk[i]) begin
            if (clr) begin
                m_blk[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
            end else if (sticky_c[i] == 0) begin
                if (!c) begin
                    m_blk[i] = 0; m_run[i] = 0;
                end else begin
                    m_info[i] = info_of(ax); m_idx[i] = low_of(ax);
                end
            end
        end else if (clr) begin
            m_run[i] = 0; m_cnt[i] = 0;
        end else if (c) begin
            m_run[i]++;
            if (m_run[i] >= hold_c[i]) begin
                m_blk[i] = 1; evt = 1; m_run[i] = 0;
                m_info[i] = info_of(ax); m_idx[i] = low_of(ax);
                if (m_cnt[i] < cmax_c[i]) m_cnt[i]++;
            end
        end else begin
            m_run[i] = 0;
        end
        e.rst  = rst;
        e.blk  = m_blk[i];
        e.evt  = evt;
        e.info = m_blk[i] ? m_info[i] : 0;
        e.idx  = rst ? 0 : m_idx[i];
        e.cnt  = m_cnt[i];
        exp_q[i].push_back(e);
    endfunction

    task automatic drive(bit rst, logic [2:0] ax, logic [1:0] idl, logic [1:0] ib,
                         logic [1:0] sb, logic [3:0] clr);
        @(negedge clock);
        reset = rst;
        if0.axis_block_sigs = ax; if0.inst_idle_sigs = idl;
        if0.inst_block_sigs = ib; if0.sub_block_sigs = sb; if0.clear = clr[0];
        if1.axis_block_sigs = ax; if1.inst_idle_sigs = idl;
        if1.inst_block_sigs = ib; if1.sub_block_sigs = sb; if1.clear = clr[1];
        if2.axis_block_sigs = ax; if2.inst_idle_sigs = idl;
        if2.inst_block_sigs = ib; if2.sub_block_sigs = sb; if2.clear = clr[2];
        if3.axis_block_sigs = ax; if3.inst_idle_sigs = idl;
        if3.inst_block_sigs = ib; if3.sub_block_sigs = sb; if3.clear = clr[3];
        for (int i = 0; i < NI; i++) void'(model_step(i, rst, ax, idl, ib, sb, clr[i]));
    endtask

    task automatic check(int i, logic blk, logic evt, logic [8:0] info, int idx, int cnt);
        exp_t e = exp_q[i].pop_front();
        n_vec++;
        if (blk !== e.blk) begin
            n_err++; $display("FAIL dut%0d block: got %b want %0d", i, blk, e.blk);
        end
        if (evt !== e.evt) begin
            n_err++; $display("FAIL dut%0d block_event: got %b want %0d", i, evt, e.evt);
        end
        if (info !== 9'(e.info)) begin
            n_err++; $display("FAIL dut%0d axis_block_info: got %h want %h", i, info, 9'(e.info));
        end
        if ((e.blk || e.rst) && idx != e.idx) begin
            n_err++; $display("FAIL dut%0d first_axis_idx: got %0d want %0d", i, idx, e.idx);
        end
        if (cnt != e.cnt) begin
            n_err++; $display("FAIL dut%0d event_count: got %0d want %0d", i, cnt, e.cnt);
        end
    endtask

    // Monitor: one expected entry per instance per clock edge
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q[0].size() > 0)
                check(0, if0.block, if0.block_event, if0.axis_block_info,
                      int'(if0.first_axis_idx), int'(if0.event_count));
            if (exp_q[1].size() > 0)
                check(1, if1.block, if1.block_event, if1.axis_block_info,
                      int'(if1.first_axis_idx), int'(if1.event_count));
            if (exp_q[2].size() > 0)
                check(2, if2.block, if2.block_event, if2.axis_block_info,
                      int'(if2.first_axis_idx), int'(if2.event_count));
            if (exp_q[3].size() > 0)
                check(3, if3.block, if3.block_event, if3.axis_block_info,
                      int'(if3.first_axis_idx), int'(if3.event_count));
        end
    end

    initial begin
        repeat (2) drive(1, 3'b000, 2'b11, 2'b00, 2'b11, 4'h0);
        // Single deadlock cycle, then stalls removed while latched
        drive(0, 3'b001, 2'b00, 2'b10, 2'b11, 4'h0);
        repeat (3) drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'h0);
        drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'hF);
        drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'h0);
        drive(0, 3'b001, 2'b00, 2'b10, 2'b11, 4'h0);
        repeat (2) drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'h0);
        drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'hF);
        // Hold-off: three deadlock cycles, a gap, then four
        repeat (3) drive(0, 3'b001, 2'b00, 2'b10, 2'b11, 4'h0);
        drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'h0);
        repeat (4) drive(0, 3'b001, 2'b00, 2'b10, 2'b11, 4'h0);
        drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'hF);
        // Multi-axis snapshot and masked axis
        repeat (2) drive(0, 3'b110, 2'b00, 2'b10, 2'b11, 4'h0);
        drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'hF);
        repeat (2) drive(0, 3'b100, 2'b00, 2'b10, 2'b11, 4'h0);
        drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'hF);
        // Reset while arming and while latched
        repeat (2) drive(0, 3'b011, 2'b00, 2'b10, 2'b11, 4'h0);
        drive(1, 3'b011, 2'b00, 2'b10, 2'b11, 4'h0);
        repeat (5) drive(0, 3'b011, 2'b00, 2'b10, 2'b11, 4'h0);
        drive(1, 3'b011, 2'b00, 2'b10, 2'b11, 4'hF);
        // Event-count saturation on the 2-bit counter
        repeat (5) begin
            repeat (3) drive(0, 3'b001, 2'b00, 2'b10, 2'b11, 4'h0);
            drive(0, 3'b000, 2'b11, 2'b00, 2'b11, 4'h0);
        end
        // Randomized runs of held input patterns
        for (int k = 0; k < 2000; k++) begin
            logic [2:0] ax  = 3'($urandom);
            logic [1:0] idl = 2'($urandom) & 2'($urandom);
            logic [1:0] ib  = 2'($urandom);
            logic [1:0] sb  = 2'($urandom) | 2'($urandom) | 2'($urandom);
            logic [3:0] clr;
            bit rst = ($urandom_range(0, 299) == 0);
            int len = $urandom_range(1, 6);
            for (int i = 0; i < NI; i++) clr[i] = ($urandom_range(0, 39) == 0);
            drive(rst, ax, idl, ib, sb, clr);
            repeat (len - 1) drive(0, ax, idl, ib, sb, 4'h0);
        end
        repeat (2) @(posedge clock);
        #3;
        for (int i = 0; i < NI; i++) begin
            if (exp_q[i].size() != 0) begin
                n_err++;
                $display("FAIL dut%0d drain: got %0d pending want 0", i, exp_q[i].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
